// File: rtl/eth_frame_gen_pkg.sv
// Shared types and constants for the Ethernet frame generator.
package eth_frame_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_GAP,
        ST_DONE
    } state_t;

    // Destination MAC (6) + source MAC (6) + EtherType (2).
    localparam int unsigned HDR_LEN = 14;

    localparam logic [1:0] MODE_INCR  = 2'd0;
    localparam logic [1:0] MODE_PRBS8 = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
    localparam logic [7:0] PRBS8_TAPS = 8'hB8;
    localparam logic [7:0] PRBS8_SEED = 8'hFF;

    // Per-frame configuration captured at every frame boundary.
    typedef struct packed {
        logic [15:0] len;
        logic [31:0] gap;
        logic [1:0]  mode;
        logic [7:0]  fill;
        logic [31:0] limit;
    } cfg_t;

    function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                              input logic [15:0] lo,
                                              input logic [15:0] hi);
        if (len < lo)
            return lo;
        else if (len > hi)
            return hi;
        else
            return len;
    endfunction

endpackage

// File: rtl/eth_frame_gen_if.sv
// Byte-wide AXI4-Stream link between the frame generator and the MAC.
interface eth_frame_gen_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_frame_gen_prbs8.sv
// PRBS8 payload source: reloads the seed on load_i, steps on advance_i.
module eth_frame_gen_prbs8
    import eth_frame_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       advance_i,
    output logic [7:0] prbs_o
);

    logic [7:0] lfsr_q;

    // Seed at frame start, otherwise shift in the XOR of the tapped bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_q <= PRBS8_SEED;
        else if (load_i)
            lfsr_q <= PRBS8_SEED;
        else if (advance_i)
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & PRBS8_TAPS)};
    end

    assign prbs_o = lfsr_q;

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet frame generator: header + patterned payload onto AXI4-Stream,
// with inter-frame gap, per-run frame limit and sent-frame/byte counters.
module eth_frame_gen
    import eth_frame_gen_pkg::*;
#(
    parameter int unsigned C_MIN_LEN = 60,
    parameter int unsigned C_MAX_LEN = 1514
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   time_running,
    input  logic [47:0]            dst_mac,
    input  logic [47:0]            src_mac,
    input  logic [15:0]            ethertype,
    input  logic [15:0]            frame_length,
    input  logic [31:0]            gap_cycles,
    input  logic [1:0]             payload_mode,
    input  logic [7:0]             fill_byte,
    input  logic [31:0]            frame_limit,
    eth_frame_gen_if.master        m_axis,
    output logic                   busy,
    output logic [63:0]            frames_sent,
    output logic [63:0]            bytes_sent
);

    state_t       state_q;
    cfg_t         cfg_q;
    cfg_t         cfg_in;
    logic [111:0] hdr_q;          // header bytes, next byte to send in the top 8 bits
    logic [15:0]  idx_q;          // byte index within the current frame
    logic [31:0]  frames_run_q;
    logic [31:0]  gap_cnt_q;
    logic         tvalid_q;
    logic         busy_q;
    logic [63:0]  frames_q;
    logic [63:0]  bytes_q;

    logic         run;
    logic         accept;
    logic         is_last;
    logic         limit_hit;
    logic         start_frame;
    logic [7:0]   prbs_byte;
    logic [7:0]   pay_idx;
    logic [7:0]   tdata;

    assign run     = enable & time_running;
    assign accept  = tvalid_q & m_axis.tready;
    assign is_last = (state_q == ST_PAYLOAD) && (idx_q == cfg_q.len - 16'd1);
    assign limit_hit = (cfg_q.limit != 32'd0) && (frames_run_q + 32'd1 == cfg_q.limit);

    // A new frame begins from IDLE, at the end of a gap, or back-to-back
    // straight after a tlast handshake when no gap is configured.
    assign start_frame = run && ((state_q == ST_IDLE) ||
                                 (state_q == ST_GAP && gap_cnt_q == 32'd1) ||
                                 (accept && is_last && !limit_hit && cfg_q.gap == 32'd0));

    // Live configuration with the length already clamped, ready to be latched.
    always_comb begin
        cfg_in       = '0;
        cfg_in.len   = clamp_len(frame_length, 16'(C_MIN_LEN), 16'(C_MAX_LEN));
        cfg_in.gap   = gap_cycles;
        cfg_in.mode  = payload_mode;
        cfg_in.fill  = fill_byte;
        cfg_in.limit = frame_limit;
    end

    // Frame sequencing, counters and registered stream handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cfg_q        <= '0;
            hdr_q        <= '0;
            idx_q        <= '0;
            frames_run_q <= '0;
            gap_cnt_q    <= '0;
            tvalid_q     <= 1'b0;
            busy_q       <= 1'b0;
            frames_q     <= '0;
            bytes_q      <= '0;
        end else begin
            if (accept)
                bytes_q <= bytes_q + 64'd1;
            if (accept && is_last)
                frames_q <= frames_q + 64'd1;

            case (state_q)
                ST_IDLE: begin
                    tvalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (run)
                        frames_run_q <= '0;
                end
                ST_HEADER: begin
                    if (accept) begin
                        hdr_q <= {hdr_q[103:0], 8'h00};
                        idx_q <= idx_q + 16'd1;
                        if (idx_q == 16'(HDR_LEN - 1))
                            state_q <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        if (is_last) begin
                            frames_run_q <= frames_run_q + 32'd1;
                            if (limit_hit) begin
                                state_q  <= ST_DONE;
                                tvalid_q <= 1'b0;
                                busy_q   <= 1'b0;
                            end else if (!run) begin
                                state_q  <= ST_IDLE;
                                tvalid_q <= 1'b0;
                                busy_q   <= 1'b0;
                            end else if (cfg_q.gap != 32'd0) begin
                                state_q   <= ST_GAP;
                                tvalid_q  <= 1'b0;
                                gap_cnt_q <= cfg_q.gap;
                            end
                        end else begin
                            idx_q <= idx_q + 16'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 32'd1) begin
                        if (!run) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 32'd1;
                    end
                end
                ST_DONE: begin
                    tvalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (!run)
                        state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    tvalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase

            // Frame start overrides the state branches: latch config, restart at byte 0.
            if (start_frame) begin
                cfg_q    <= cfg_in;
                hdr_q    <= {dst_mac, src_mac, ethertype};
                idx_q    <= '0;
                state_q  <= ST_HEADER;
                tvalid_q <= 1'b1;
                busy_q   <= 1'b1;
            end
        end
    end

    eth_frame_gen_prbs8 u_prbs8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (start_frame),
        .advance_i (accept && state_q == ST_PAYLOAD),
        .prbs_o    (prbs_byte)
    );

    assign pay_idx = idx_q[7:0] - 8'(HDR_LEN);

    // Byte mux; everything feeding it is registered so it holds during stalls.
    always_comb begin
        tdata = 8'h00;
        if (tvalid_q) begin
            if (state_q == ST_HEADER) begin
                tdata = hdr_q[111:104];
            end else begin
                case (cfg_q.mode)
                    MODE_PRBS8:           tdata = prbs_byte;
                    MODE_CONST:           tdata = cfg_q.fill;
                    MODE_INCR, MODE_RSVD: tdata = pay_idx;
                    default:              tdata = pay_idx;
                endcase
            end
        end
    end

    assign m_axis.tdata  = tdata;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tvalid_q & is_last;
    assign busy          = busy_q;
    assign frames_sent   = frames_q;
    assign bytes_sent    = bytes_q;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Scoreboard bench for eth_frame_gen: a frame-level reference model queues
// the expected beats, an independent monitor checks every accepted beat.
module tb_eth_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        time_running = 1'b0;
    logic [47:0] dst_mac = '0;
    logic [47:0] src_mac = '0;
    logic [15:0] ethertype = '0;
    logic [15:0] frame_length = 16'd64;
    logic [31:0] gap_cycles = '0;
    logic [1:0]  payload_mode = '0;
    logic [7:0]  fill_byte = '0;
    logic [31:0] frame_limit = '0;
    logic        busy;
    logic [63:0] frames_sent;
    logic [63:0] bytes_sent;

    eth_frame_gen_if axis ();

    eth_frame_gen #(.C_MIN_LEN(60), .C_MAX_LEN(1514)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .time_running (time_running),
        .dst_mac      (dst_mac),
        .src_mac      (src_mac),
        .ethertype    (ethertype),
        .frame_length (frame_length),
        .gap_cycles   (gap_cycles),
        .payload_mode (payload_mode),
        .fill_byte    (fill_byte),
        .frame_limit  (frame_limit),
        .m_axis       (axis),
        .busy         (busy),
        .frames_sent  (frames_sent),
        .bytes_sent   (bytes_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         gap;   // idle cycles expected before this beat, -1 = unchecked
    } beat_t;

    beat_t       sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          beat_cnt = 0;
    bit          rand_ready = 1'b0;
    logic [63:0] exp_frames = '0;
    logic [63:0] exp_bytes = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // x^8+x^6+x^5+x^4+1: new bit is the XOR of stages 8,6,5,4, shifted in at the bottom.
    function automatic logic [7:0] prbs_next(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    // Reference model: expected beats of one frame from the current config.
    task automatic push_frame(input int gap_before, input int max_beats);
        int         len;
        int         n;
        logic [7:0] s;
        logic [7:0] b;
        beat_t      e;
        len = int'(frame_length);
        if (len < 60)   len = 60;
        if (len > 1514) len = 1514;
        n = (max_beats < len) ? max_beats : len;
        s = 8'hFF;
        for (int i = 0; i < n; i++) begin
            if (i < 6)
                b = 8'(dst_mac >> (8 * (5 - i)));
            else if (i < 12)
                b = 8'(src_mac >> (8 * (11 - i)));
            else if (i < 14)
                b = 8'(ethertype >> (8 * (13 - i)));
            else if (payload_mode == 2'd1) begin
                b = s;
                s = prbs_next(s);
            end else if (payload_mode == 2'd2)
                b = fill_byte;
            else
                b = 8'((i - 14) % 256);
            e.d   = b;
            e.l   = (i == len - 1);
            e.gap = (i == 0) ? gap_before : -1;
            sb.push_back(e);
        end
        if (n == len) begin
            exp_frames = exp_frames + 64'd1;
            exp_bytes  = exp_bytes + 64'(len);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout, %0d beats still expected, 0 required", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic rand_hdr();
        dst_mac   = {16'($urandom), $urandom};
        src_mac   = {16'($urandom), $urandom};
        ethertype = 16'($urandom);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frames"}, frames_sent, exp_frames);
        check({tag, "_bytes"}, bytes_sent, exp_bytes);
    endtask

    // MAC ready: always-on, or random stalls when rand_ready is set.
    initial begin
        axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            axis.tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability and gaps.
    initial begin
        logic       pv, pr, pl;
        logic [7:0] pd;
        int         idle;
        beat_t      e;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; idle = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                idle = 0;
            end else begin
                if (pv && !pr) begin
                    check("stall_tvalid", 64'(axis.tvalid), 64'd1);
                    check("stall_tdata", 64'(axis.tdata), 64'(pd));
                    check("stall_tlast", 64'(axis.tlast), 64'(pl));
                end
                if (axis.tvalid && axis.tready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got tdata 0x%0h, expected no beat", axis.tdata);
                    end else begin
                        e = sb.pop_front();
                        $display("beat %0d: tdata=0x%02h tlast=%0b", beat_cnt, axis.tdata, axis.tlast);
                        check("tdata", 64'(axis.tdata), 64'(e.d));
                        check("tlast", 64'(axis.tlast), 64'(e.l));
                        if (e.gap >= 0)
                            check("gap_cycles", 64'(idle), 64'(e.gap));
                    end
                    beat_cnt++;
                    if (axis.tlast)
                        idle = 0;
                end else if (!axis.tvalid) begin
                    idle++;
                end
                pv = axis.tvalid;
                pr = axis.tready;
                pd = axis.tdata;
                pl = axis.tlast;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;

        // Reset state
        step(3);
        check("rst_tvalid", 64'(axis.tvalid), 64'd0);
        check("rst_tlast", 64'(axis.tlast), 64'd0);
        check("rst_tdata", 64'(axis.tdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check_counters("rst");
        rst_n = 1'b1;
        step(2);

        // Two 64-byte incrementing frames, 12-cycle gap, limit 2
        rand_hdr();
        frame_length = 16'd64; gap_cycles = 32'd12; payload_mode = 2'd0; frame_limit = 32'd2;
        push_frame(-1, 100000);
        push_frame(12, 100000);
        enable = 1'b1; time_running = 1'b1;
        @(negedge clk);
        check("latency_before", 64'(axis.tvalid), 64'd0);
        @(negedge clk);
        check("latency_after", 64'(axis.tvalid), 64'd1);
        wait_empty("t1_frames", 400);
        step(20);
        check("t1_done_tvalid", 64'(axis.tvalid), 64'd0);
        check("t1_done_busy", 64'(busy), 64'd0);
        check_counters("t1");
        enable = 1'b0;
        step(3);

        // Length clamping: short request raised, long request clipped
        frame_length = 16'd20; gap_cycles = 32'd5; frame_limit = 32'd1;
        push_frame(-1, 100000);
        enable = 1'b1;
        wait_empty("t2_short", 300);
        step(5);
        check_counters("t2_short");
        time_running = 1'b0;
        step(3);
        frame_length = 16'd2000;
        push_frame(-1, 100000);
        time_running = 1'b1;
        wait_empty("t2_long", 2000);
        step(5);
        check_counters("t2_long");
        enable = 1'b0;
        step(3);

        // PRBS8 payload under random backpressure, seed restarts per frame
        rand_hdr();
        frame_length = 16'($urandom_range(60, 120));
        gap_cycles = 32'($urandom_range(1, 5));
        payload_mode = 2'd1; frame_limit = 32'd2;
        push_frame(-1, 100000);
        push_frame(int'(gap_cycles), 100000);
        rand_ready = 1'b1;
        enable = 1'b1;
        wait_empty("t3_prbs", 2000);
        rand_ready = 1'b0;
        step(10);
        check_counters("t3");
        enable = 1'b0;
        step(3);

        // Enable dropped mid-frame: frame completes, then idle
        rand_hdr();
        frame_length = 16'd100; gap_cycles = 32'd3; payload_mode = 2'd0; frame_limit = 32'd0;
        push_frame(-1, 100000);
        base = beat_cnt;
        enable = 1'b1;
        k = 0;
        while (beat_cnt - base < 30 && k < 200) begin
            step(1);
            k++;
        end
        enable = 1'b0;
        wait_empty("t4_drop", 300);
        step(20);
        check("t4_tvalid", 64'(axis.tvalid), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check_counters("t4");

        // Back-to-back constant-fill frames, gap 0, limit 3
        rand_hdr();
        frame_length = 16'($urandom_range(60, 90));
        gap_cycles = 32'd0; payload_mode = 2'd2; fill_byte = 8'hA5; frame_limit = 32'd3;
        push_frame(-1, 100000);
        push_frame(0, 100000);
        push_frame(0, 100000);
        enable = 1'b1;
        wait_empty("t5_b2b", 1000);
        step(5);
        check("t5_busy", 64'(busy), 64'd0);
        check_counters("t5");
        enable = 1'b0;
        step(3);

        // Reset mid-frame at beat 40, then a clean restart
        rand_hdr();
        frame_length = 16'd100; gap_cycles = 32'd4; payload_mode = 2'd0; frame_limit = 32'd0;
        push_frame(-1, 40);
        enable = 1'b1;
        wait_empty("t6_pre_reset", 300);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", 64'(axis.tvalid), 64'd0);
        check("t6_rst_tlast", 64'(axis.tlast), 64'd0);
        check("t6_rst_tdata", 64'(axis.tdata), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        exp_frames = '0;
        exp_bytes  = '0;
        check_counters("t6_rst");
        enable = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        frame_length = 16'd64; frame_limit = 32'd1;
        push_frame(-1, 100000);
        enable = 1'b1;
        wait_empty("t6_restart", 300);
        step(5);
        check_counters("t6_restart");
        enable = 1'b0;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eth_frame_gen.md
Name: eth_frame_gen

Overview:
- Ethernet frame generator: the transmit-side counterpart of the stats collector.
- Drives a byte-wide AXI4-Stream master into the MAC TX interface with configurable header, length, payload pattern, inter-frame gap and frame limit.
- Keeps its own sent-frame and sent-byte counters so the stats collector's TX figures can be cross-checked.

Parameters:
- C_MIN_LEN, 60, minimum frame length in bytes, excluding FCS; shorter requests are raised to it.
- C_MAX_LEN, 1514, maximum frame length in bytes; longer requests are clipped to it.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request; level-sensitive.
- time_running  in  1  generation is allowed only while high; ANDed with enable.
- dst_mac  in  48  destination MAC, sent MSB byte first.
- src_mac  in  48  source MAC, sent MSB byte first.
- ethertype  in  16  EtherType, sent MSB byte first.
- frame_length  in  16  total bytes per frame, header included.
- gap_cycles  in  32  idle cycles between frames.
- payload_mode  in  2  0 = incrementing, 1 = PRBS8, 2 = constant, 3 = reserved (behaves as 0).
- fill_byte  in  8  constant used in mode 2.
- frame_limit  in  32  frames to send per run; 0 = unlimited.
- m_axis_tdata  out  8  stream byte.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tlast  out  1  last byte of frame.
- m_axis_tready  in  1  MAC ready.
- busy  out  1  high in any state other than IDLE or DONE.
- frames_sent  out  64  frames whose tlast byte was accepted.
- bytes_sent  out  64  bytes accepted (every tvalid&tready beat).

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0.
- Reset asserted mid-frame aborts immediately, with no tlast.
- run = enable & time_running.

FSM states: IDLE, HEADER, PAYLOAD, GAP, DONE.
- IDLE:
  - When run is sampled high, latch all config inputs into shadow registers.
  - Clamp the latched length to [C_MIN_LEN, C_MAX_LEN].
  - Clear byte index and frames-this-run, then go to HEADER.
  - tvalid rises the cycle after run is sampled (1-cycle latency).
- HEADER:
  - Bytes 0..13 are dst_mac, src_mac, ethertype.
  - After byte 13 is accepted, go to PAYLOAD.
- PAYLOAD:
  - Bytes 14..len-1.
  - tlast is high on byte len-1.
- Payload content:
  - Mode 0: byte value = (index - 14) mod 256.
  - Mode 1: Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded 0xFF at each frame start; output the register, then advance on each accepted beat.
  - Mode 2: fill_byte.
- Index advances only on tvalid & tready.
- AXI4-Stream rules:
  - tdata and tlast are held stable while tvalid & ~tready.
  - tvalid never drops mid-frame, including when run deasserts.
- On tlast handshake:
  - Increment frames_sent and frames-this-run.
  - If frame_limit != 0 and frames-this-run == frame_limit, go to DONE.
  - Else if run == 0, go to IDLE.
  - Else if latched gap == 0, go to HEADER with tvalid held high (back-to-back).
  - Else go to GAP.
- GAP:
  - tvalid low for exactly gap_cycles cycles.
  - Then re-latch config and go to HEADER if run is high, otherwise go to IDLE.
- DONE: tvalid low; return to IDLE when run is 0.
- Config changes take effect only at frame boundaries (on latch).
- Counters:
  - 64-bit, wrap to 0 past 2^64-1.
  - Not cleared by disable; cleared only by rst_n.
  - bytes_sent increments by 1 on each accepted beat.

Decomposition:
- Package eth_frame_gen_pkg holds:
  - the state enum;
  - the header length constant (14);
  - payload mode constants;
  - the PRBS8 tap mask 0xB8 and seed 0xFF.
- One sub-module, eth_frame_gen_prbs8: LFSR with load (seed) and advance inputs, 8-bit output.

Test Plan:
- len=64, gap=12, mode 0, tready=1, limit=2 → 2 frames of 64 beats each.
  - Bytes 14..63 are 0x00..0x31; tlast on beats 63 and 127.
  - Exactly 12 idle cycles between frames.
  - frames_sent=2, bytes_sent=128; FSM in DONE, busy=0.
- len=20 (below min) and len=2000 (above max) → frames of 60 and 1514 beats respectively.
- Random tready stalls, mode 1 → tdata/tlast stable while stalled.
  - First payload bytes are 0xFF followed by the PRBS8 sequence.
  - Sequence restarts from 0xFF in the second frame.
- enable dropped at beat 30 of a 100-byte frame → frame completes with tlast at beat 99, then IDLE; frames_sent=1.
- gap=0, limit=3, mode 2 with fill=0xA5 → 3 frames back-to-back.
  - tvalid stays continuously high across all 3 frames.
  - Payload bytes are all 0xA5.
- rst_n asserted at beat 40 → outputs 0 immediately; after release, a fresh run restarts at byte 0 with counters at 0.
